// File: rtl/pll_lock_sequencer.sv
// PLL bring-up/lock supervisor: drives PLL RST/PWRDWN, retries on lock timeout and
// releases channel resets in staggered order. Define PLL_LOCK_SEQ_STATS_EN for O_LOSS_CNT/O_LAST_LOCK_CYC.
module pll_lock_sequencer #(
    parameter int unsigned NUM_CH         = 6,
    parameter int unsigned RST_HOLD       = 16,
    parameter int unsigned LOCK_STABLE    = 4,
    parameter int unsigned LOCK_TIMEOUT   = 1024,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned STAGGER_CYCLES = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              I_PWRDWN,
    input  logic              I_LOCKED,
    output logic              O_PLL_RST,
    output logic              O_PLL_PWRDWN,
    output logic [NUM_CH-1:0] O_CH_RST_N,
    output logic              O_READY,
    output logic              O_FAIL,
    output logic [3:0]        O_RETRY_CNT
`ifdef PLL_LOCK_SEQ_STATS_EN
    ,
    output logic [7:0]        O_LOSS_CNT,
    output logic [15:0]       O_LAST_LOCK_CYC
`endif
);

    localparam int unsigned TMR_MAX = (RST_HOLD > LOCK_TIMEOUT) ? RST_HOLD : LOCK_TIMEOUT;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX) + 1;
    localparam int unsigned STB_W   = $clog2(LOCK_STABLE) + 1;
    localparam int unsigned STG_W   = $clog2(STAGGER_CYCLES) + 1;

    localparam logic [TMR_W-1:0]  HOLD_LAST    = TMR_W'(RST_HOLD - 1);
    localparam logic [TMR_W-1:0]  TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [STB_W-1:0]  STB_DONE     = STB_W'(LOCK_STABLE);
    localparam logic [STG_W-1:0]  STG_LAST     = STG_W'(STAGGER_CYCLES - 1);
    localparam logic [3:0]        RETRY_MAX    = 4'(MAX_RETRIES);
    localparam logic [NUM_CH-1:0] CH_ONE       = NUM_CH'(1);

    typedef enum logic [2:0] {
        S_RESET_HOLD,
        S_WAIT_LOCK,
        S_STAGGER,
        S_RUN,
        S_PWRDN,
        S_FAIL
    } state_t;

    state_t            state_q;
    logic [TMR_W-1:0]  timer_q;
    logic [STB_W-1:0]  stab_q, stab_d;
    logic [STG_W-1:0]  stag_q;
    logic [1:0]        sync_q;
    logic              pll_rst_q, pwrdwn_q, ready_q, fail_q;
    logic [NUM_CH-1:0] ch_rst_n_q, ch_rst_n_d;
    logic [3:0]        retry_q;
    logic              locked_s, lock_ok;

    assign locked_s = sync_q[1];

    // Channels release LSB first: shifting a 1 in from the bottom gives ascending order.
    always_comb begin
        stab_d     = locked_s ? stab_q + 1'b1 : '0;
        lock_ok    = (stab_d == STB_DONE);
        ch_rst_n_d = (ch_rst_n_q << 1) | CH_ONE;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= S_RESET_HOLD;
            timer_q    <= '0;
            stab_q     <= '0;
            stag_q     <= '0;
            sync_q     <= '0;
            pll_rst_q  <= 1'b1;
            pwrdwn_q   <= 1'b0;
            ch_rst_n_q <= '0;
            ready_q    <= 1'b0;
            fail_q     <= 1'b0;
            retry_q    <= '0;
        end else begin
            sync_q <= {sync_q[0], I_LOCKED};
            if (I_PWRDWN) begin
                state_q    <= S_PWRDN;
                timer_q    <= '0;
                stab_q     <= '0;
                stag_q     <= '0;
                pll_rst_q  <= 1'b1;
                pwrdwn_q   <= 1'b1;
                ch_rst_n_q <= '0;
                ready_q    <= 1'b0;
                fail_q     <= 1'b0;
                retry_q    <= '0;
            end else begin
                case (state_q)
                    S_PWRDN: begin
                        state_q  <= S_RESET_HOLD;
                        timer_q  <= '0;
                        pwrdwn_q <= 1'b0;
                    end
                    S_RESET_HOLD: begin
                        if (timer_q == HOLD_LAST) begin
                            state_q   <= S_WAIT_LOCK;
                            timer_q   <= '0;
                            stab_q    <= '0;
                            pll_rst_q <= 1'b0;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    S_WAIT_LOCK: begin
                        stab_q  <= stab_d;
                        timer_q <= timer_q + 1'b1;
                        if (lock_ok) begin
                            state_q <= S_STAGGER;
                            stag_q  <= '0;
                        end else if (timer_q == TIMEOUT_LAST) begin
                            timer_q   <= '0;
                            pll_rst_q <= 1'b1;
                            if (retry_q < RETRY_MAX) begin
                                retry_q <= retry_q + 4'd1;
                                state_q <= S_RESET_HOLD;
                            end else begin
                                state_q <= S_FAIL;
                                fail_q  <= 1'b1;
                            end
                        end
                    end
                    S_STAGGER, S_RUN: begin
                        if (!locked_s) begin
                            // Loss of lock: drop every channel at once, retry count untouched.
                            state_q    <= S_RESET_HOLD;
                            timer_q    <= '0;
                            pll_rst_q  <= 1'b1;
                            ch_rst_n_q <= '0;
                            ready_q    <= 1'b0;
                        end else if (state_q == S_STAGGER) begin
                            if (stag_q == STG_LAST) begin
                                stag_q     <= '0;
                                ch_rst_n_q <= ch_rst_n_d;
                                if (ch_rst_n_d == '1) begin
                                    state_q <= S_RUN;
                                    ready_q <= 1'b1;
                                    retry_q <= '0;
                                end
                            end else begin
                                stag_q <= stag_q + 1'b1;
                            end
                        end
                    end
                    S_FAIL: begin
                        pll_rst_q <= 1'b1;
                        fail_q    <= 1'b1;
                    end
                    default: begin
                        state_q   <= S_RESET_HOLD;
                        timer_q   <= '0;
                        pll_rst_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign O_PLL_RST    = pll_rst_q;
    assign O_PLL_PWRDWN = pwrdwn_q;
    assign O_CH_RST_N   = ch_rst_n_q;
    assign O_READY      = ready_q;
    assign O_FAIL       = fail_q;
    assign O_RETRY_CNT  = retry_q;

`ifdef PLL_LOCK_SEQ_STATS_EN
    logic [7:0]  loss_cnt_q;
    logic [15:0] last_lock_q, last_lock_d;
    logic        loss_evt, lock_evt;
    logic [31:0] wait_cycles;

    // Recorded value is the number of WAIT_LOCK cycles including the accepting one.
    always_comb begin
        loss_evt    = !I_PWRDWN && !locked_s && (state_q == S_STAGGER || state_q == S_RUN);
        lock_evt    = !I_PWRDWN && lock_ok && (state_q == S_WAIT_LOCK);
        wait_cycles = 32'(timer_q) + 32'd1;
        last_lock_d = (wait_cycles > 32'd65535) ? 16'hFFFF : wait_cycles[15:0];
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            loss_cnt_q  <= '0;
            last_lock_q <= '0;
        end else begin
            if (loss_evt && loss_cnt_q != 8'hFF) loss_cnt_q <= loss_cnt_q + 8'd1;
            if (lock_evt) last_lock_q <= last_lock_d;
        end
    end

    assign O_LOSS_CNT      = loss_cnt_q;
    assign O_LAST_LOCK_CYC = last_lock_q;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer (default parameters): vector table,
// hand-written retry/FAIL sequences and randomized stimulus against a behavioural model.
module tb_pll_lock_sequencer;

    localparam int NUM_CH      = 6;
    localparam int RST_HOLD    = 16;
    localparam int LOCK_STABLE = 4;
    localparam int LOCK_TMO    = 1024;
    localparam int MAX_RETRIES = 3;
    localparam int STAGGER     = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pwr = 1'b0;
    logic              lock = 1'b0;
    logic              o_rst, o_pwr, o_rdy, o_fail;
    logic [NUM_CH-1:0] o_ch;
    logic [3:0]        o_retry;
`ifdef PLL_LOCK_SEQ_STATS_EN
    logic [7:0]        o_loss;
    logic [15:0]       o_last;
`endif

    pll_lock_sequencer dut (
        .CLK          (clk),
        .RST_N        (rst_n),
        .I_PWRDWN     (pwr),
        .I_LOCKED     (lock),
        .O_PLL_RST    (o_rst),
        .O_PLL_PWRDWN (o_pwr),
        .O_CH_RST_N   (o_ch),
        .O_READY      (o_rdy),
        .O_FAIL       (o_fail),
        .O_RETRY_CNT  (o_retry)
`ifdef PLL_LOCK_SEQ_STATS_EN
        ,
        .O_LOSS_CNT      (o_loss),
        .O_LAST_LOCK_CYC (o_last)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_pack();
        return {18'b0, o_rst, o_pwr, o_ch, o_rdy, o_fail, o_retry};
    endfunction

    // Behavioural model: phase plus cycles elapsed in that phase.
    typedef enum {P_OFF, P_HOLD, P_WAIT, P_STAG, P_RUN, P_DEAD} phase_t;
    phase_t m_phase = P_HOLD;
    int     m_n = 0;
    int     m_retry = 0;
    bit     m_s1 = 0, m_s2 = 0;
    bit     hist[$];
`ifdef PLL_LOCK_SEQ_STATS_EN
    int     m_loss = 0;
    int     m_last = 0;
`endif

    function automatic bit lock_run_ok();
        if (hist.size() < LOCK_STABLE) return 0;
        for (int i = 0; i < LOCK_STABLE; i++)
            if (!hist[hist.size() - 1 - i]) return 0;
        return 1;
    endfunction

    function automatic void model_step();
        bit ls;
        ls   = m_s2;
        m_s2 = m_s1;
        m_s1 = lock;
        if (!rst_n) begin
            m_phase = P_HOLD; m_n = 0; m_retry = 0; m_s1 = 0; m_s2 = 0;
`ifdef PLL_LOCK_SEQ_STATS_EN
            m_loss = 0; m_last = 0;
`endif
            return;
        end
        if (pwr) begin
            m_phase = P_OFF; m_n = 0; m_retry = 0;
            return;
        end
        case (m_phase)
            P_OFF: begin m_phase = P_HOLD; m_n = 0; end
            P_HOLD: begin
                m_n++;
                if (m_n == RST_HOLD) begin m_phase = P_WAIT; m_n = 0; hist.delete(); end
            end
            P_WAIT: begin
                hist.push_back(ls);
                m_n++;
                if (lock_run_ok()) begin
`ifdef PLL_LOCK_SEQ_STATS_EN
                    m_last = (m_n > 65535) ? 65535 : m_n;
`endif
                    m_phase = P_STAG; m_n = 0;
                end else if (m_n == LOCK_TMO) begin
                    if (m_retry < MAX_RETRIES) begin m_retry++; m_phase = P_HOLD; end
                    else m_phase = P_DEAD;
                    m_n = 0;
                end
            end
            P_STAG, P_RUN: begin
                if (!ls) begin
                    m_phase = P_HOLD; m_n = 0;
`ifdef PLL_LOCK_SEQ_STATS_EN
                    if (m_loss < 255) m_loss++;
`endif
                end else if (m_phase == P_STAG) begin
                    m_n++;
                    if (m_n == STAGGER * NUM_CH) begin m_phase = P_RUN; m_retry = 0; end
                end
            end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] model_pack();
        logic [NUM_CH-1:0] ch;
        logic e_rst, e_pwr, e_rdy, e_fail;
        ch = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (m_phase == P_RUN || (m_phase == P_STAG && m_n >= STAGGER * (k + 1))) ch[k] = 1'b1;
        e_rst  = (m_phase == P_OFF || m_phase == P_HOLD || m_phase == P_DEAD);
        e_pwr  = (m_phase == P_OFF);
        e_rdy  = (m_phase == P_RUN);
        e_fail = (m_phase == P_DEAD);
        return {18'b0, e_rst, e_pwr, ch, e_rdy, e_fail, 4'(m_retry)};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        string       name;
        logic        rst_n, pwr, lock;
        int          cyc;
        logic        e_rst, e_pwr;
        logic [5:0]  e_ch;
        logic        e_rdy, e_fail;
        logic [3:0]  e_retry;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input string nm, input logic r, input logic p, input logic l, input int c,
                       input logic er, input logic ep, input logic [5:0] ech, input logic erd);
        vec_t v;
        v.name = nm; v.rst_n = r; v.pwr = p; v.lock = l; v.cyc = c;
        v.e_rst = er; v.e_pwr = ep; v.e_ch = ech; v.e_rdy = erd; v.e_fail = 1'b0; v.e_retry = 4'd0;
        vecs.push_back(v);
    endtask

    initial begin
        int cnt;
        int kind;
        int len;
        logic released;
        logic rst_before;

        //   name         rst_n pwr lock cyc  rst pwr ch          rdy
        add("reset",      0, 0, 1,  3,  1, 0, 6'b000000, 0);
        add("hold_end",   1, 0, 1, 15,  1, 0, 6'b000000, 0);
        add("rst_fall",   1, 0, 1,  1,  0, 0, 6'b000000, 0);
        add("lock_acc",   1, 0, 1,  4,  0, 0, 6'b000000, 0);
        add("pre_ch0",    1, 0, 1,  7,  0, 0, 6'b000000, 0);
        add("ch0",        1, 0, 1,  1,  0, 0, 6'b000001, 0);
        add("ch1",        1, 0, 1,  8,  0, 0, 6'b000011, 0);
        add("pre_ch5",    1, 0, 1, 31,  0, 0, 6'b011111, 0);
        add("ready",      1, 0, 1,  1,  0, 0, 6'b111111, 1);
        add("drop",       1, 0, 0,  1,  0, 0, 6'b111111, 1);
        add("sync_lat",   1, 0, 1,  1,  0, 0, 6'b111111, 1);
        add("loss",       1, 0, 1,  1,  1, 0, 6'b000000, 0);
        add("rehold",     1, 0, 1, 15,  1, 0, 6'b000000, 0);
        add("rerel",      1, 0, 1,  1,  0, 0, 6'b000000, 0);
        add("pre_rdy2",   1, 0, 1, 51,  0, 0, 6'b011111, 0);
        add("rdy2",       1, 0, 1,  1,  0, 0, 6'b111111, 1);
        add("pwr_run",    1, 1, 1,  1,  1, 1, 6'b000000, 0);
        add("pwr_hold",   1, 1, 1,  3,  1, 1, 6'b000000, 0);
        add("pwr_rel",    1, 0, 1,  1,  1, 0, 6'b000000, 0);
        add("hold2",      1, 0, 1, 15,  1, 0, 6'b000000, 0);
        add("rel2",       1, 0, 1,  1,  0, 0, 6'b000000, 0);
        add("stag3",      1, 0, 1, 28,  0, 0, 6'b000111, 0);
        add("pwr_stag",   1, 1, 1,  1,  1, 1, 6'b000000, 0);
        add("pwr_rel2",   1, 0, 1,  1,  1, 0, 6'b000000, 0);
        add("hold3",      1, 0, 1, 15,  1, 0, 6'b000000, 0);
        add("rel3",       1, 0, 1,  1,  0, 0, 6'b000000, 0);
        add("rdy3",       1, 0, 1, 52,  0, 0, 6'b111111, 1);
        add("rst_run",    0, 0, 1,  1,  1, 0, 6'b000000, 0);

        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n; pwr = vecs[i].pwr; lock = vecs[i].lock;
            for (int c = 0; c < vecs[i].cyc; c++) tick();
            check(vecs[i].name, dut_pack(),
                  {18'b0, vecs[i].e_rst, vecs[i].e_pwr, vecs[i].e_ch,
                   vecs[i].e_rdy, vecs[i].e_fail, vecs[i].e_retry});
        end

        // Never locked: four 16-cycle RST pulses, 1024 WAIT_LOCK cycles apart, then FAIL.
        rst_n = 0; lock = 0; pwr = 0;
        tick(); tick();
        rst_n = 1;
        for (int a = 0; a < 4; a++) begin
            cnt = 0;
            while (o_rst === 1'b1 && cnt < 100) begin tick(); cnt++; end
            check($sformatf("fail_rst_pulse%0d", a), cnt, RST_HOLD);
            cnt = 0;
            while (o_rst === 1'b0 && cnt < 2000) begin tick(); cnt++; end
            check($sformatf("fail_wait%0d", a), cnt, LOCK_TMO);
            check($sformatf("fail_retry%0d", a), o_retry, (a < 3) ? a + 1 : 3);
            check($sformatf("fail_flag%0d", a), o_fail, (a == 3) ? 1 : 0);
        end
        for (int c = 0; c < 50; c++) tick();
        check("fail_hold", dut_pack(), {18'b0, 1'b1, 1'b0, 6'b0, 1'b0, 1'b1, 4'd3});
        rst_n = 0;
        tick();
        check("rst_in_fail", dut_pack(), {18'b0, 1'b1, 1'b0, 6'b0, 1'b0, 1'b0, 4'd0});

        // Lock toggling 3 high / 3 low never meets the 4-cycle stability requirement.
        lock = 0;
        tick();
        rst_n = 1;
        released = 1'b0;
        rst_before = 1'b1;
        for (int c = 1; c <= RST_HOLD + LOCK_TMO; c++) begin
            lock = (c > RST_HOLD) ? (((c - RST_HOLD - 1) % 6) < 3) : 1'b0;
            tick();
            if (o_ch !== '0) released = 1'b1;
            if (c == RST_HOLD + LOCK_TMO - 1) rst_before = o_rst;
        end
        check("toggle_no_release", {31'b0, released}, 32'd0);
        check("toggle_rst_before_tmo", {31'b0, rst_before}, 32'd0);
        check("toggle_retry", o_retry, 32'd1);
        check("toggle_rst_again", {31'b0, o_rst}, 32'd1);

        // Randomized stimulus against the model, starting from a clean reset.
        rst_n = 0; pwr = 0; lock = 1;
        tick(); tick();
        rst_n = 1;
        for (int s = 0; s < 60; s++) begin
            kind = $urandom_range(0, 10);
            case (kind)
                0, 1, 2, 3, 4, 5: begin lock = 1; len = $urandom_range(20, 200); end
                6:       begin lock = 0; len = $urandom_range(1, 6); end
                7:       begin pwr = 1;  len = $urandom_range(1, 5); end
                8:       len = $urandom_range(10, 40);
                9:       begin lock = 0; len = $urandom_range(900, 2500); end
                default: begin rst_n = 0; len = $urandom_range(1, 3); end
            endcase
            for (int c = 0; c < len; c++) begin
                if (kind == 8) lock = 1'($urandom_range(0, 1));
                tick();
                check("rand_out", dut_pack(), model_pack());
`ifdef PLL_LOCK_SEQ_STATS_EN
                check("rand_loss_cnt", o_loss, m_loss);
                check("rand_last_lock", o_last, m_last);
`endif
            end
            pwr = 0;
            rst_n = 1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Parametrised PLL bring-up and lock supervisor, clocked from the PLL reference clock.
- Drives the PLLE2 RST and PWRDWN inputs, synchronises the PLL LOCKED output, and retries on lock timeout.
- Releases NUM_CH per-output-domain resets in a staggered order once lock is stable.
- Recovers automatically on loss of lock; replaces the ad-hoc "RST || !LOCKED" counter reset used in PLL feature tests.

Parameters:
- NUM_CH, 6: number of downstream channel resets (1..16).
- RST_HOLD, 16: cycles O_PLL_RST is held per reset attempt (>=1).
- LOCK_STABLE, 4: consecutive synchronised-lock cycles required before lock is accepted (>=1).
- LOCK_TIMEOUT, 1024: WAIT_LOCK cycles before an attempt is abandoned (>LOCK_STABLE).
- MAX_RETRIES, 3: reset attempts after the first before FAIL (0..15).
- STAGGER_CYCLES, 8: spacing between successive channel reset releases (>=1).

Ports:
- CLK, in, 1: reference clock; all logic is on its rising edge.
- RST_N, in, 1: synchronous, active-low reset.
- I_PWRDWN, in, 1: power-down request, level-sensitive, synchronous to CLK.
- I_LOCKED, in, 1: raw PLL LOCKED, asynchronous to CLK.
- O_PLL_RST, out, 1: to PLL RST.
- O_PLL_PWRDWN, out, 1: to PLL PWRDWN.
- O_CH_RST_N, out, NUM_CH: per-channel active-low resets; bit k is channel k.
- O_READY, out, 1: all channels released, PLL locked.
- O_FAIL, out, 1: retries exhausted.
- O_RETRY_CNT, out, 4: attempts abandoned since the last RUN or power-down.

Behaviour:
- Clock and reset: one clock (CLK). Reset is synchronous and active-low (RST_N), with priority over everything.
- Reset values: state RESET_HOLD, timers 0, O_PLL_RST=1, O_PLL_PWRDWN=0, O_CH_RST_N=0, O_READY=0, O_FAIL=0, O_RETRY_CNT=0.
- Lock synchroniser: 2-flop synchroniser resets to 0. locked_s is its output, 2 cycles of latency. All outputs are registered.
- I_PWRDWN=1 in any state: next state PWRDN. I_PWRDWN has priority over all lock and timer events.
- PWRDN: O_PLL_PWRDWN=1, O_PLL_RST=1, O_CH_RST_N=0, O_READY=0, O_FAIL=0, retry counter cleared. On I_PWRDWN=0, go to RESET_HOLD with timer 0.
- RESET_HOLD: O_PLL_RST=1, all channels in reset. Timer counts 0..RST_HOLD-1; on the final count, go to WAIT_LOCK. O_PLL_RST=0 from WAIT_LOCK's first cycle, so it is high for exactly RST_HOLD cycles after reset release.
- WAIT_LOCK:
  - Timer and a stability counter run.
  - Stability counter clears whenever locked_s=0. When it reaches LOCK_STABLE, go to STAGGER.
  - If the timer reaches LOCK_TIMEOUT-1 first: with retry count < MAX_RETRIES, increment it and go to RESET_HOLD; otherwise go to FAIL.
  - If lock acceptance and timeout occur in the same cycle, lock wins.
- STAGGER:
  - Channel k is released (O_CH_RST_N[k]=1) STAGGER_CYCLES*(k+1) cycles after STAGGER entry, in ascending order.
  - Release of channel NUM_CH-1 coincides with O_READY=1, the transition to RUN, and the retry counter clearing to 0.
- RUN: hold. Any cycle with locked_s=0 in STAGGER or RUN is a loss of lock:
  - On the next edge, O_CH_RST_N=0 and O_READY=0 for all channels together.
  - State goes to RESET_HOLD.
  - The retry counter is not incremented.
- FAIL: O_FAIL=1, O_PLL_RST=1, channels in reset, O_RETRY_CNT=MAX_RETRIES. Exit only via RST_N or I_PWRDWN.
- Counter widths: each is $clog2 of its limit plus 1. No wrap-around is reachable.

Optional Feature:
- Macro: PLL_LOCK_SEQ_STATS_EN.
- Defined:
  - Adds output O_LOSS_CNT [7:0], a count of loss-of-lock events in STAGGER/RUN.
  - Saturates at 255 and resets to 0 only on RST_N; power-down does not clear it.
  - Adds output O_LAST_LOCK_CYC [15:0], the WAIT_LOCK cycle count at the most recent lock acceptance, saturating at 65535.
- Undefined: neither port nor their registers exist. All other behaviour is identical.

Test Plan:
- Defaults, I_LOCKED=1 before reset release -> O_PLL_RST high for 16 cycles after RST_N rises; lock accepted 4 cycles into WAIT_LOCK; O_CH_RST_N[0] rises 8 cycles after STAGGER entry and bit 5 at 48; O_READY rises with bit 5.
- I_LOCKED=0 throughout, MAX_RETRIES=3 -> 4 RST pulses of 16 cycles each, spaced by 1024 WAIT_LOCK cycles; O_FAIL=1; O_RETRY_CNT=3; O_CH_RST_N=6'b0 stays.
- In RUN, I_LOCKED dropped for 1 cycle -> 2 cycles later O_CH_RST_N=0 and O_READY=0; O_PLL_RST=1 for 16 cycles; full re-sequence; O_RETRY_CNT unchanged at 0.
- I_LOCKED toggles with a period of 6 cycles (high for 3) in WAIT_LOCK -> never accepted (needs 4); timeout and retry occur.
- I_PWRDWN=1 mid-STAGGER with 3 channels released -> next edge all O_CH_RST_N=0, O_PLL_PWRDWN=1; after I_PWRDWN=0, sequence restarts from RESET_HOLD.
- RST_N=0 asserted in RUN and in FAIL -> all outputs return to reset values on the next edge. With PLL_LOCK_SEQ_STATS_EN and 3 lock losses, O_LOSS_CNT=3.
